// File: rtl/inst_mem_arbiter.sv
// Arbiter sharing a single-port synchronous instruction memory between fetch (F) and loader (L).
// Optional fetch starvation guard is enabled by defining INST_ARB_STARVE_GUARD_EN.
module inst_mem_arbiter #(
   parameter int ADDR_LEN   = 32,
   parameter int INSTR_LEN  = 32,
   parameter int IDX_LEN    = 8,
   parameter int STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 f_valid,
   output logic                 f_ready,
   input  logic [ADDR_LEN-1:0]  f_addr,
   output logic                 f_rsp_valid,
   output logic [INSTR_LEN-1:0] f_rsp_data,
   output logic                 f_rsp_err,
   input  logic                 l_valid,
   output logic                 l_ready,
   input  logic                 l_we,
   input  logic [ADDR_LEN-1:0]  l_addr,
   input  logic [INSTR_LEN-1:0] l_wdata,
   input  logic                 l_lock,
   output logic                 l_rsp_valid,
   output logic [INSTR_LEN-1:0] l_rsp_data,
   output logic                 l_rsp_err,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [IDX_LEN-1:0]   mem_idx,
   output logic [INSTR_LEN-1:0] mem_wdata,
   input  logic [INSTR_LEN-1:0] mem_rdata
);

   typedef enum logic [2:0] {OWN_NONE, OWN_F, OWN_L, OWN_F_ERR, OWN_L_ERR} owner_e;

   owner_e rsp_owner_q, rsp_owner_d;
   logic   rsp_wr_q, rsp_wr_d;
   logic   f_err, l_err, guard_trip, grant_f, grant_l;

   // Valid/ready: a request completes in the cycle valid & ready; its response
   // appears exactly one cycle later and cannot be stalled.
   assign f_err = (f_addr[1:0] != 2'b00) || (f_addr[ADDR_LEN-1:IDX_LEN+2] != '0);
   assign l_err = (l_addr[1:0] != 2'b00) || (l_addr[ADDR_LEN-1:IDX_LEN+2] != '0);

`ifdef INST_ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

   assign guard_trip = (starve_cnt_q == CNT_W'(STARVE_MAX)) && f_valid && !l_lock;

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (grant_f || !f_valid) begin
         starve_cnt_d = '0;
      end else if (grant_l && !l_lock && (starve_cnt_q != CNT_W'(STARVE_MAX))) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) starve_cnt_q <= '0;
      else        starve_cnt_q <= starve_cnt_d;
   end
`else
   assign guard_trip = 1'b0;
`endif

   // Grants are held off entirely while reset is asserted.
   assign grant_l = rst_n && l_valid && !guard_trip;
   assign grant_f = rst_n && !grant_l && f_valid && !l_lock;
   assign l_ready = grant_l;
   assign f_ready = grant_f;

   always_comb begin
      rsp_owner_d = OWN_NONE;
      rsp_wr_d    = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_idx     = '0;
      mem_wdata   = '0;
      if (grant_l) begin
         rsp_owner_d = l_err ? OWN_L_ERR : OWN_L;
         rsp_wr_d    = l_we;
         mem_en      = !l_err;
         mem_we      = l_we && !l_err;
         mem_idx     = l_addr[IDX_LEN+1:2];
         mem_wdata   = l_wdata;
      end else if (grant_f) begin
         rsp_owner_d = f_err ? OWN_F_ERR : OWN_F;
         mem_en      = !f_err;
         mem_idx     = f_addr[IDX_LEN+1:2];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_owner_q <= OWN_NONE;
         rsp_wr_q    <= 1'b0;
      end else begin
         rsp_owner_q <= rsp_owner_d;
         rsp_wr_q    <= rsp_wr_d;
      end
   end

   assign f_rsp_valid = (rsp_owner_q == OWN_F) || (rsp_owner_q == OWN_F_ERR);
   assign f_rsp_err   = (rsp_owner_q == OWN_F_ERR);
   assign f_rsp_data  = (rsp_owner_q == OWN_F) ? mem_rdata : '0;
   assign l_rsp_valid = (rsp_owner_q == OWN_L) || (rsp_owner_q == OWN_L_ERR);
   assign l_rsp_err   = (rsp_owner_q == OWN_L_ERR);
   assign l_rsp_data  = ((rsp_owner_q == OWN_L) && !rsp_wr_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Directed bench for inst_mem_arbiter with a behavioural 256-word synchronous memory.
module tb_inst_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        f_valid, f_ready, f_rsp_valid, f_rsp_err;
   logic [31:0] f_addr, f_rsp_data;
   logic        l_valid, l_ready, l_we, l_lock, l_rsp_valid, l_rsp_err;
   logic [31:0] l_addr, l_wdata, l_rsp_data;
   logic        mem_en, mem_we;
   logic [7:0]  mem_idx;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;

   logic [31:0] mem_q [256];
   bit          written [256];
   logic [31:0] exp_q [$];

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   inst_mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .f_valid(f_valid), .f_ready(f_ready), .f_addr(f_addr),
      .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data), .f_rsp_err(f_rsp_err),
      .l_valid(l_valid), .l_ready(l_ready), .l_we(l_we), .l_addr(l_addr),
      .l_wdata(l_wdata), .l_lock(l_lock),
      .l_rsp_valid(l_rsp_valid), .l_rsp_data(l_rsp_data), .l_rsp_err(l_rsp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   function automatic logic [31:0] init_word(int i);
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   // Unwritten locations read back a fixed per-index pattern.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            mem_q[mem_idx]   <= mem_wdata;
            written[mem_idx] <= 1'b1;
         end else begin
            mem_rdata <= written[mem_idx] ? mem_q[mem_idx] : init_word(int'(mem_idx));
         end
      end
   end

   task automatic idle();
      f_valid = 1'b0; f_addr = 32'h0;
      l_valid = 1'b0; l_we = 1'b0; l_addr = 32'h0; l_wdata = 32'h0; l_lock = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; f_valid = 1'b1; l_valid = 1'b1; l_addr = 32'h4;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk_cnt++; if ({f_ready, l_ready, mem_en, mem_we} !== 4'b0000) $display("FAIL reset_ctrl got=%b exp=0000", {f_ready, l_ready, mem_en, mem_we}); else pass_cnt++;
      chk_cnt++; if ({f_rsp_valid, f_rsp_err, l_rsp_valid, l_rsp_err} !== 4'b0000) $display("FAIL reset_rsp got=%b exp=0000", {f_rsp_valid, f_rsp_err, l_rsp_valid, l_rsp_err}); else pass_cnt++;
      chk_cnt++; if ({f_rsp_data, l_rsp_data} !== 64'h0) $display("FAIL reset_data got=%h exp=0", {f_rsp_data, l_rsp_data}); else pass_cnt++;
      idle();
      rst_n = 1'b1;
   endtask

   task automatic test_f_only();
      @(negedge clk); f_valid = 1'b1; f_addr = 32'h4; #1;
      chk_cnt++; if ({f_ready, l_ready, mem_en, mem_we} !== 4'b1010) $display("FAIL f_only_ctrl got=%b exp=1010", {f_ready, l_ready, mem_en, mem_we}); else pass_cnt++;
      chk_cnt++; if (mem_idx !== 8'd1) $display("FAIL f_only_idx got=%0d exp=1", mem_idx); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if ({f_rsp_valid, f_rsp_err, l_rsp_valid} !== 3'b100) $display("FAIL f_only_rsp got=%b exp=100", {f_rsp_valid, f_rsp_err, l_rsp_valid}); else pass_cnt++;
      chk_cnt++; if (f_rsp_data !== 32'hC0DE_0001) $display("FAIL f_only_data got=%h exp=c0de0001", f_rsp_data); else pass_cnt++;
      @(negedge clk); idle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_w;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); f_valid = 1'b1; f_addr = 32'(k * 4);
         exp_q.push_back(32'hC0DE_0000 | 32'(k));
         @(posedge clk); #1;
         exp_w = exp_q.pop_front();
         chk_cnt++; if (f_rsp_valid !== 1'b1 || f_rsp_data !== exp_w) $display("FAIL b2b_%0d got=%b/%h exp=1/%h", k, f_rsp_valid, f_rsp_data, exp_w); else pass_cnt++;
      end
      @(negedge clk); idle();
      @(posedge clk); #1;
      chk_cnt++; if (f_rsp_valid !== 1'b0) $display("FAIL b2b_end got=%b exp=0", f_rsp_valid); else pass_cnt++;
   endtask

   task automatic test_write_then_read();
      @(negedge clk); l_valid = 1'b1; l_we = 1'b1; l_addr = 32'h14; l_wdata = 32'hDEAD_BEEF; #1;
      chk_cnt++; if ({f_ready, l_ready, mem_en, mem_we} !== 4'b0111) $display("FAIL wr_ctrl got=%b exp=0111", {f_ready, l_ready, mem_en, mem_we}); else pass_cnt++;
      chk_cnt++; if ({mem_idx, mem_wdata} !== {8'd5, 32'hDEAD_BEEF}) $display("FAIL wr_bus got=%h exp=05deadbeef", {mem_idx, mem_wdata}); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if ({l_rsp_valid, l_rsp_err, f_rsp_valid} !== 3'b100 || l_rsp_data !== 32'h0) $display("FAIL wr_rsp got=%b/%h exp=100/0", {l_rsp_valid, l_rsp_err, f_rsp_valid}, l_rsp_data); else pass_cnt++;
      @(negedge clk); idle(); f_valid = 1'b1; f_addr = 32'h14;
      @(posedge clk); #1;
      chk_cnt++; if (f_rsp_valid !== 1'b1 || f_rsp_data !== 32'hDEAD_BEEF) $display("FAIL wr_fetch got=%b/%h exp=1/deadbeef", f_rsp_valid, f_rsp_data); else pass_cnt++;
      @(negedge clk); idle(); l_valid = 1'b1; l_addr = 32'h14;
      @(posedge clk); #1;
      chk_cnt++; if ({l_rsp_valid, l_rsp_err, f_rsp_valid} !== 3'b100 || l_rsp_data !== 32'hDEAD_BEEF) $display("FAIL l_read got=%b/%h exp=100/deadbeef", {l_rsp_valid, l_rsp_err, f_rsp_valid}, l_rsp_data); else pass_cnt++;
      @(negedge clk); idle();
   endtask

   task automatic test_errors();
      logic [31:0] err_addr [2];
      err_addr[0] = 32'h2;
      err_addr[1] = 32'h400;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); f_valid = 1'b1; f_addr = err_addr[k]; #1;
         chk_cnt++; if ({f_ready, mem_en} !== 2'b10) $display("FAIL f_err_ctrl_%0d got=%b exp=10", k, {f_ready, mem_en}); else pass_cnt++;
         @(posedge clk); #1;
         chk_cnt++; if ({f_rsp_valid, f_rsp_err} !== 2'b11 || f_rsp_data !== 32'h0) $display("FAIL f_err_rsp_%0d got=%b/%h exp=11/0", k, {f_rsp_valid, f_rsp_err}, f_rsp_data); else pass_cnt++;
      end
      @(negedge clk); idle(); l_valid = 1'b1; l_addr = 32'h8000_0000; #1;
      chk_cnt++; if ({l_ready, mem_en} !== 2'b10) $display("FAIL l_err_ctrl got=%b exp=10", {l_ready, mem_en}); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if ({l_rsp_valid, l_rsp_err} !== 2'b11 || l_rsp_data !== 32'h0) $display("FAIL l_err_rsp got=%b/%h exp=11/0", {l_rsp_valid, l_rsp_err}, l_rsp_data); else pass_cnt++;
      @(negedge clk); idle();
   endtask

   task automatic test_starve();
      logic [5:0] exp_lg;
`ifdef INST_ARB_STARVE_GUARD_EN
      exp_lg = 6'b101111;
`else
      exp_lg = 6'b111111;
`endif
      @(negedge clk); f_valid = 1'b1; f_addr = 32'h0; l_valid = 1'b1; l_addr = 32'h8;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk_cnt++; if ({l_ready, f_ready} !== {exp_lg[i], ~exp_lg[i]}) $display("FAIL starve_grant_%0d got=%b exp=%b", i, {l_ready, f_ready}, {exp_lg[i], ~exp_lg[i]}); else pass_cnt++;
         @(posedge clk); #1;
         chk_cnt++; if ({l_rsp_valid, f_rsp_valid} !== {exp_lg[i], ~exp_lg[i]}) $display("FAIL starve_rsp_%0d got=%b exp=%b", i, {l_rsp_valid, f_rsp_valid}, {exp_lg[i], ~exp_lg[i]}); else pass_cnt++;
         @(negedge clk);
      end
      idle();
   endtask

   task automatic test_lock();
      @(negedge clk); f_valid = 1'b1; f_addr = 32'h8; #1;
      chk_cnt++; if (f_ready !== 1'b1) $display("FAIL lock_pre got=%b exp=1", f_ready); else pass_cnt++;
      @(negedge clk); l_lock = 1'b1; #1;
      chk_cnt++; if ({f_ready, mem_en} !== 2'b00) $display("FAIL lock_ctrl got=%b exp=00", {f_ready, mem_en}); else pass_cnt++;
      chk_cnt++; if (f_rsp_valid !== 1'b1 || f_rsp_data !== 32'hC0DE_0002) $display("FAIL lock_inflight got=%b/%h exp=1/c0de0002", f_rsp_valid, f_rsp_data); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if (f_rsp_valid !== 1'b0) $display("FAIL lock_norsp got=%b exp=0", f_rsp_valid); else pass_cnt++;
      @(negedge clk); idle();
   endtask

   task automatic test_reset_inflight();
      @(negedge clk); f_valid = 1'b1; f_addr = 32'hC; #1;
      chk_cnt++; if (f_ready !== 1'b1) $display("FAIL rst_grant got=%b exp=1", f_ready); else pass_cnt++;
      @(negedge clk); rst_n = 1'b0; l_valid = 1'b1; l_addr = 32'h4; #1;
      chk_cnt++; if ({f_ready, l_ready, mem_en, mem_we} !== 4'b0000) $display("FAIL rst_hold got=%b exp=0000", {f_ready, l_ready, mem_en, mem_we}); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if ({f_rsp_valid, f_rsp_err, l_rsp_valid, l_rsp_err} !== 4'b0000 || {f_rsp_data, l_rsp_data} !== 64'h0) $display("FAIL rst_drop got=%b/%h exp=0000/0", {f_rsp_valid, f_rsp_err, l_rsp_valid, l_rsp_err}, {f_rsp_data, l_rsp_data}); else pass_cnt++;
      @(negedge clk); idle(); rst_n = 1'b1;
      @(posedge clk); #1;
      chk_cnt++; if ({f_rsp_valid, l_rsp_valid} !== 2'b00) $display("FAIL rst_after got=%b exp=00", {f_rsp_valid, l_rsp_valid}); else pass_cnt++;
   endtask

   initial begin
      idle();
      test_reset();
      test_f_only();
      test_back_to_back();
      test_write_then_read();
      test_errors();
      test_starve();
      test_lock();
      test_reset_inflight();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

endmodule
